// File: rtl/systolic_feed_ctrl.sv
// Feed sequencer for a DIM x DIM systolic MAC grid: fetches K operand column/row pairs,
// applies per-lane diagonal skew, and frames the PE clear/start window plus done/overflow status.
module systolic_feed_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 4,
  parameter int K_MAX      = 16,
  localparam int KW        = $clog2(K_MAX + 1),
  localparam int AW        = $clog2(K_MAX)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [KW-1:0]             k_len_i,
  output logic                      rd_en_o,
  output logic [AW-1:0]             a_rd_addr_o,
  output logic [AW-1:0]             b_rd_addr_o,
  input  logic [DIM*DATA_WIDTH-1:0] a_col_i,
  input  logic [DIM*DATA_WIDTH-1:0] b_row_i,
  output logic [DIM*DATA_WIDTH-1:0] pe_a_o,
  output logic [DIM*DATA_WIDTH-1:0] pe_b_o,
  output logic                      pe_start_o,
  output logic                      pe_clr_o,
  input  logic [DIM*DIM-1:0]        pe_ov_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      ov_o
);

  // Cycle counter spans the whole run (cycle 1 = CLEAR) and never wraps.
  localparam int CW = $clog2(K_MAX + 2*DIM + 4);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_FETCH, ST_DRAIN, ST_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cyc_reg, cyc_next;
  logic [KW-1:0]   k_reg;
  logic            ov_reg;
  logic [KW-1:0]   k_sat;
  logic [CW-1:0]   k_ext;
  logic            in_valid;
  logic            start_ok;

  assign k_sat    = (k_len_i > KW'(K_MAX)) ? KW'(K_MAX) : k_len_i;
  assign k_ext    = CW'(k_reg);
  assign start_ok = (state_reg == ST_IDLE) && start_i && !abort_i;

  always_comb begin
    state_next = state_reg;
    cyc_next   = cyc_reg + CW'(1);
    case (state_reg)
      ST_IDLE: begin
        cyc_next = '0;
        if (start_i) begin
          cyc_next   = CW'(1);
          state_next = (k_len_i == '0) ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR: state_next = ST_FETCH;
      ST_FETCH: if (cyc_reg == k_ext + CW'(1)) state_next = ST_DRAIN;
      ST_DRAIN: if (cyc_reg == k_ext + CW'(2*DIM + 2)) state_next = ST_DONE;
      ST_DONE: begin
        state_next = ST_IDLE;
        cyc_next   = '0;
      end
      default: begin
        state_next = ST_IDLE;
        cyc_next   = '0;
      end
    endcase
    if (abort_i) begin
      state_next = ST_IDLE;
      cyc_next   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= ST_IDLE;
      cyc_reg   <= '0;
      k_reg     <= '0;
      ov_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
      if (start_ok) begin
        k_reg  <= k_sat;
        ov_reg <= 1'b0;
      end else if (state_reg == ST_DONE && !abort_i) begin
        // A zero-length run never touches the grid, so it reports no overflow.
        ov_reg <= (k_reg != '0) && (|pe_ov_i);
      end
    end
  end

  assign rd_en_o     = (state_reg == ST_FETCH);
  assign a_rd_addr_o = rd_en_o ? AW'(cyc_reg - CW'(2)) : '0;
  assign b_rd_addr_o = a_rd_addr_o;
  assign pe_clr_o    = (state_reg == ST_CLEAR);
  assign pe_start_o  = (state_reg == ST_FETCH || state_reg == ST_DRAIN) && (cyc_reg >= CW'(4));
  assign busy_o      = (state_reg != ST_IDLE);
  assign done_o      = (state_reg == ST_DONE);
  assign ov_o        = ov_reg;

  // Element k returns from the buffers in cycle k+3; anything else entering the skew is zeroed.
  assign in_valid = (state_reg == ST_FETCH || state_reg == ST_DRAIN) &&
                    (cyc_reg >= CW'(3)) && (cyc_reg <= k_ext + CW'(2));

  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] a_pipe_reg [0:gi];
      logic [DATA_WIDTH-1:0] b_pipe_reg [0:gi];

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          for (int s = 0; s <= gi; s++) begin
            a_pipe_reg[s] <= '0;
            b_pipe_reg[s] <= '0;
          end
        end else if (abort_i) begin
          for (int s = 0; s <= gi; s++) begin
            a_pipe_reg[s] <= '0;
            b_pipe_reg[s] <= '0;
          end
        end else begin
          a_pipe_reg[0] <= in_valid ? a_col_i[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
          b_pipe_reg[0] <= in_valid ? b_row_i[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
          for (int s = 1; s <= gi; s++) begin
            a_pipe_reg[s] <= a_pipe_reg[s-1];
            b_pipe_reg[s] <= b_pipe_reg[s-1];
          end
        end
      end

      assign pe_a_o[gi*DATA_WIDTH +: DATA_WIDTH] = a_pipe_reg[gi];
      assign pe_b_o[gi*DATA_WIDTH +: DATA_WIDTH] = b_pipe_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Randomized bench for systolic_feed_ctrl: per-cycle comparison of every output against a
// cycle-indexed reference built from the run's K, abort point and operand memories.
module tb_systolic_feed_ctrl;
  localparam int DW    = 8;
  localparam int DIM   = 4;
  localparam int K_MAX = 16;
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int AW    = $clog2(K_MAX);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start_i = 1'b0;
  logic                abort_i = 1'b0;
  logic [KW-1:0]       k_len_i = '0;
  logic                rd_en_o;
  logic [AW-1:0]       a_rd_addr_o, b_rd_addr_o;
  logic [DIM*DW-1:0]   a_col_i = '0, b_row_i = '0;
  logic [DIM*DW-1:0]   pe_a_o, pe_b_o;
  logic                pe_start_o, pe_clr_o;
  logic [DIM*DIM-1:0]  pe_ov_i = '0;
  logic                busy_o, done_o, ov_o;

  logic [DIM*DW-1:0]   amem [K_MAX];
  logic [DIM*DW-1:0]   bmem [K_MAX];

  int n_vec = 0;
  int n_bad = 0;

  systolic_feed_ctrl #(.DATA_WIDTH(DW), .DIM(DIM), .K_MAX(K_MAX)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_i), .abort_i(abort_i), .k_len_i(k_len_i),
    .rd_en_o(rd_en_o), .a_rd_addr_o(a_rd_addr_o), .b_rd_addr_o(b_rd_addr_o),
    .a_col_i(a_col_i), .b_row_i(b_row_i), .pe_a_o(pe_a_o), .pe_b_o(pe_b_o),
    .pe_start_o(pe_start_o), .pe_clr_o(pe_clr_o), .pe_ov_i(pe_ov_i),
    .busy_o(busy_o), .done_o(done_o), .ov_o(ov_o)
  );

  always #5 clk = ~clk;

  // Operand buffers: one-cycle read latency; junk on the bus when not reading.
  always @(posedge clk) begin
    if (rd_en_o) begin
      a_col_i <= amem[a_rd_addr_o];
      b_row_i <= bmem[b_rd_addr_o];
    end else begin
      a_col_i <= $urandom;
      b_row_i <= $urandom;
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] observe();
    return {50'b0, busy_o, rd_en_o, pe_clr_o, pe_start_o, done_o, ov_o,
            a_rd_addr_o, pe_a_o, pe_b_o};
  endfunction

  // Expected outputs in cycle c of a run (cycle 0 = start edge); ca=0 means no abort.
  function automatic logic [127:0] model(int c, int keff, int ca, logic ov_fin);
    int done_c;
    logic live, busy, clr, rd, st, dn, ov;
    logic [AW-1:0] addr;
    logic [DIM*DW-1:0] la, lb;
    logic [DIM*DW-1:0] wa, wb;
    done_c = (keff == 0) ? 1 : keff + 2*DIM + 3;
    live = (ca == 0) || (c <= ca);
    busy = live && c >= 1 && c <= done_c;
    clr  = live && keff > 0 && c == 1;
    rd   = live && keff > 0 && c >= 2 && c <= keff + 1;
    addr = rd ? AW'(c - 2) : '0;
    st   = live && keff > 0 && c >= 4 && c <= keff + 2*DIM + 2;
    dn   = live && c == done_c;
    ov   = (ca == 0 && keff > 0 && c > done_c) ? ov_fin : 1'b0;
    la = '0;
    lb = '0;
    for (int i = 0; i < DIM; i++) begin
      int k;
      k = c - 4 - i;
      if (live && k >= 0 && k < keff) begin
        wa = amem[k];
        wb = bmem[k];
        la[i*DW +: DW] = wa[i*DW +: DW];
        lb[i*DW +: DW] = wb[i*DW +: DW];
      end
    end
    return {50'b0, busy, rd, clr, st, dn, ov, addr, la, lb};
  endfunction

  // One start-to-idle run; rst_at>0 pulls reset asynchronously in that cycle and ends the run.
  task automatic run(input int kreq, input int ca, input bit pulse_start,
                     input int mem_mode, input int rst_at);
    int keff, done_c, pc;
    logic ov_fin;
    keff   = (kreq > K_MAX) ? K_MAX : kreq;
    done_c = (keff == 0) ? 1 : keff + 2*DIM + 3;
    pc     = (done_c < 3) ? done_c : 3;
    for (int k = 0; k < K_MAX; k++) begin
      if (mem_mode == 1) begin
        amem[k] = {DIM{8'(k + 1)}};
        bmem[k] = {DIM{8'(k + 1)}};
      end else begin
        amem[k] = $urandom;
        bmem[k] = $urandom;
      end
    end
    pe_ov_i = ($urandom_range(0, 1) == 1) ? 16'($urandom) : '0;
    ov_fin  = |pe_ov_i;
    @(posedge clk); #1;
    start_i = 1'b1;
    k_len_i = KW'(kreq);
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 1; c <= done_c + 3; c++) begin
      @(negedge clk);
      check_eq($sformatf("k%0d_ab%0d_cyc%0d", kreq, ca, c), observe(), model(c, keff, ca, ov_fin));
      if (rst_at != 0 && c == rst_at) begin
        #2 rst_n = 1'b0;
        #1 check_eq("async_reset_mid_drain", observe(), 128'b0);
        @(posedge clk); #1;
        check_eq("reset_held_idle", observe(), 128'b0);
        rst_n = 1'b1;
        return;
      end
      abort_i = (c == ca);
      start_i = pulse_start && (c == pc) && (ca == 0 || c <= ca);
      @(posedge clk); #1;
      abort_i = 1'b0;
      start_i = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check_eq("reset_state", observe(), 128'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(4, 0, 1'b0, 0, 0);    // basic K=4 timing
    run(4, 0, 1'b1, 1, 0);    // skew pattern k+1 on all lanes, stray start during FETCH
    run(0, 0, 1'b1, 0, 0);    // zero-length run, stray start during DONE
    run(16, 0, 1'b0, 0, 0);   // full K_MAX
    run(20, 0, 1'b0, 0, 0);   // saturates to K_MAX
    run(8, 7, 1'b0, 0, 0);    // abort at cycle 7
    run(5, 0, 1'b0, 0, 0);    // restart after abort
    run(1, 0, 1'b1, 0, 0);    // shortest nonzero run
    run(6, 0, 1'b1, 0, 10);   // reset in DRAIN
    run(3, 0, 1'b0, 0, 0);    // recovers after reset

    for (int t = 0; t < 30; t++) begin
      int kr, kf, dc, ab;
      kr = $urandom_range(0, 20);
      kf = (kr > K_MAX) ? K_MAX : kr;
      dc = (kf == 0) ? 1 : kf + 2*DIM + 3;
      ab = 0;
      if (dc > 1 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, dc - 1);
      run(kr, ab, 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
